ram_fifo_ctrl: RTL and testbench

Upstream access controller for the 32x8 single-port RAM. It turns a valid/ready write stream and a valid/ready read stream into a FIFO held in the RAM, driving write_enb/read_enb/address/data_in and capturing data_out. The RAM has one port, so the block arbitrates each cycle between one write and one read. A small output queue absorbs the RAM read latency.

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_fifo_ctrl_if.sv | 30 +++
 rtl/ram_fifo_oq.sv | 42 ++++
 rtl/ram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_fifo_ctrl shared sizes, grant and token types.
// No ports; imported by the interface, queue and controller.
package ram_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int OQ_DEPTH = 3;
    localparam int CNT_W    = ADDR_W + 1;
    localparam int OQ_CW    = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;

    typedef enum logic {
        TOK_WR,
        TOK_RD
    } token_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-side signals of ram_fifo_ctrl.
// slave: controller view; master: producer/consumer/RAM view.
interface ram_fifo_ctrl_if;
    import ram_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              write_enb;
    logic              read_enb;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  level;

    modport slave (
        input  in_valid, in_data, out_ready, data_out,
        output in_ready, out_valid, out_data,
        output write_enb, read_enb, address, data_in, level
    );

    modport master (
        output in_valid, in_data, out_ready, data_out,
        input  in_ready, out_valid, out_data,
        input  write_enb, read_enb, address, data_in, level
    );
endinterface

// File: rtl/ram_fifo_oq.sv
// 3-entry output queue absorbing RAM read latency.
// Ports: i_push/i_din in, i_pop out, o_cnt fill, o_head front word.
module ram_fifo_oq
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [OQ_CW-1:0]  o_cnt,
    output logic [DATA_W-1:0] o_head
);
    logic [DATA_W-1:0] r_q [OQ_DEPTH];
    logic [OQ_CW-1:0]  r_cnt;
    logic [OQ_CW-1:0]  w_wr_idx;

    // Head is always r_q[0]; a same-cycle pop shifts the slot down.
    assign w_wr_idx = r_cnt - OQ_CW'(i_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            for (int i = 0; i < OQ_DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            if (i_pop) begin
                for (int i = 0; i < OQ_DEPTH - 1; i++) begin
                    r_q[i] <= r_q[i+1];
                end
            end
            if (i_push && (w_wr_idx < OQ_CW'(OQ_DEPTH))) begin
                r_q[w_wr_idx] <= i_din;
            end
            r_cnt <= r_cnt + OQ_CW'(i_push) - OQ_CW'(i_pop);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_q[0];
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a 32x8 single-port RAM, one access per cycle.
// Ports: clk, reset (async, low), bus (ram_fifo_ctrl_if.slave).
module ram_fifo_ctrl
    import ram_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    ram_fifo_ctrl_if.slave  bus
);
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_ram_cnt;
    logic              r_rd_pend;
    token_t            r_token;
    token_t            w_token_nxt;
    grant_t            w_grant;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_not_full;
    logic              w_wr;
    logic              w_rd;
    logic              w_pop;
    logic [OQ_CW-1:0]  w_oq_cnt;
    logic [DATA_W-1:0] w_oq_head;

    assign w_not_full = r_ram_cnt < CNT_W'(DEPTH);

    // Read only when the queue can take the word in flight;
    // out_ready is deliberately not used here.
    assign w_rd_req = (r_ram_cnt != '0) &&
                      ((3'(w_oq_cnt) + 3'(r_rd_pend)) < 3'(OQ_DEPTH));
    assign w_wr_req = reset && bus.in_valid && w_not_full;

    always_comb begin
        w_grant     = GNT_NONE;
        w_token_nxt = r_token;
        unique case (1'b1)
            (w_wr_req && w_rd_req): begin
                w_grant     = (r_token == TOK_WR) ? GNT_WR : GNT_RD;
                w_token_nxt = (r_token == TOK_WR) ? TOK_RD : TOK_WR;
            end
            (w_wr_req && !w_rd_req): w_grant = GNT_WR;
            (!w_wr_req && w_rd_req): w_grant = GNT_RD;
            default:                 w_grant = GNT_NONE;
        endcase
    end

    assign w_wr = (w_grant == GNT_WR);
    assign w_rd = (w_grant == GNT_RD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_token   <= TOK_WR;
        end else begin
            r_token   <= w_token_nxt;
            r_rd_pend <= w_rd;
            if (w_wr) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_ram_cnt <= r_ram_cnt + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_ram_cnt <= r_ram_cnt - 1'b1;
            end
        end
    end

    assign w_pop = bus.out_valid && bus.out_ready;

    ram_fifo_oq u_oq (
        .clk    (clk),
        .reset  (reset),
        .i_push (r_rd_pend),
        .i_din  (bus.data_out),
        .i_pop  (w_pop),
        .o_cnt  (w_oq_cnt),
        .o_head (w_oq_head)
    );

    assign bus.in_ready  = reset && w_not_full &&
                           !(w_rd_req && r_token == TOK_RD);
    assign bus.out_valid = (w_oq_cnt != '0);
    assign bus.out_data  = w_oq_head;
    assign bus.write_enb = w_wr;
    assign bus.read_enb  = w_rd;
    assign bus.address   = w_wr ? r_wr_ptr : r_rd_ptr;
    assign bus.data_in   = bus.in_data;
    assign bus.level     = r_ram_cnt + CNT_W'(r_rd_pend) +
                           CNT_W'(w_oq_cnt);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model plus scoreboard on the streams.
// Directed phases for reset, latency, full, arbitration, wrap, reset.
module tb_ram_fifo_ctrl;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_acc;
    int   n0;
    logic [4:0] exp_wa = '0;
    logic [4:0] exp_ra = '0;
    logic wr_wrap = 1'b0;
    logic rd_wrap = 1'b0;
    logic prev_we;
    logic [7:0] sb [$];
    logic [7:0] mem [32];

    ram_fifo_ctrl_if bus ();

    ram_fifo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.write_enb) mem[bus.address] <= bus.data_in;
        if (bus.read_enb) bus.data_out <= mem[bus.address];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("excl", int'(bus.write_enb & bus.read_enb), 0);
            chk("wr_vs_hs", int'(bus.write_enb),
                int'(bus.in_valid & bus.in_ready));
            if (bus.write_enb) begin
                chk("wr_addr", int'(bus.address), int'(exp_wa));
                chk("data_in", int'(bus.data_in), int'(bus.in_data));
                if (exp_wa == 5'd31) wr_wrap = 1'b1;
                exp_wa = exp_wa + 5'd1;
            end
            if (bus.read_enb) begin
                chk("rd_addr", int'(bus.address), int'(exp_ra));
                if (exp_ra == 5'd31) rd_wrap = 1'b1;
                exp_ra = exp_ra + 5'd1;
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("out_data", int'(bus.out_data), int'(sb.pop_front()));
            end
        end
    end

    task automatic wait_empty(input string tag);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.level == '0) break;
        end
        chk(tag, int'(bus.level), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.data_out  = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ov", int'(bus.out_valid), 0);
        chk("rst_we", int'(bus.write_enb), 0);
        chk("rst_re", int'(bus.read_enb), 0);
        chk("rst_addr", int'(bus.address), 0);
        chk("rst_lvl", int'(bus.level), 0);
        chk("rst_rdy", int'(bus.in_ready), 0);
        chk("rst_od", int'(bus.out_data), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_rdy", int'(bus.in_ready), 1);
        chk("rel_lvl", int'(bus.level), 0);

        // single word latency
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("one_we", int'(bus.write_enb), 1);
        chk("one_waddr", int'(bus.address), 0);
        chk("one_din", int'(bus.data_in), 8'hA5);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("one_re", int'(bus.read_enb), 1);
        chk("one_raddr", int'(bus.address), 0);
        chk("one_lvl1", int'(bus.level), 1);
        @(negedge clk);
        chk("one_ov0", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("one_ov1", int'(bus.out_valid), 1);
        chk("one_od", int'(bus.out_data), 8'hA5);
        @(negedge clk);
        chk("one_lvl0", int'(bus.level), 0);

        // fill to capacity with consumer stalled
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 60; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            bus.in_data = 8'(n_acc);
            @(negedge clk);
            if (bus.in_ready) n_acc++;
        end
        chk("fill_cnt", n_acc, 35);
        chk("full_rdy", int'(bus.in_ready), 0);
        chk("full_lvl", int'(bus.level), 35);
        chk("full_ov", int'(bus.out_valid), 1);
        chk("full_od", int'(bus.out_data), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n0 = n_out;
        wait_empty("drain_lvl");
        chk("drain_n", n_out - n0, 35);

        // saturated streams alternate
        @(posedge clk); #1 bus.in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1 bus.in_data = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        prev_we = bus.write_enb;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1 bus.in_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("alt_one", int'(bus.write_enb ^ bus.read_enb), 1);
            chk("alt_flip", int'(bus.write_enb), int'(!prev_we));
            prev_we = bus.write_enb;
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        wait_empty("alt_drain");
        chk("alt_sb", sb.size(), 0);

        // 40 words with random backpressure; pointers wrap
        wr_wrap = 1'b0; rd_wrap = 1'b0;
        n0 = n_out; n_acc = 0;
        for (int c = 0; c < 600 && n_acc < 40; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data = 8'($urandom_range(0, 255));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) n_acc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        wait_empty("rnd_drain");
        chk("rnd_acc", n_acc, 40);
        chk("rnd_out", n_out - n0, 40);
        chk("wr_wrap", int'(wr_wrap), 1);
        chk("rd_wrap", int'(rd_wrap), 1);

        // reset during a read cycle
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_data = 8'h77;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.read_enb) break;
        end
        chk("mid_re", int'(bus.read_enb), 1);
        #2;
        reset = 1'b0;
        sb.delete();
        exp_wa = '0; exp_ra = '0;
        #1;
        chk("mid_ov", int'(bus.out_valid), 0);
        chk("mid_lvl", int'(bus.level), 0);
        chk("mid_re0", int'(bus.read_enb), 0);
        chk("mid_rdy", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("no_stale", int'(bus.out_valid), 0);
        end
        n0 = n_out;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        wait_empty("post_drain");
        chk("post_n", n_out - n0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
